// File: rtl/wb_drain_arb.sv
// wb_drain_arb: drains up to NUM_SRC register writeback FIFOs into the
// single register-file write port.
//   clk, rst_n         clock, synchronous active-low reset
//   src_empty_i        per-FIFO empty flag
//   src_wdata_i        per-FIFO head data, slice i = [i*DATA_W +: DATA_W]
//   src_waddr_i        per-FIFO head register address (same slicing)
//   src_cid_i          per-FIFO head commit ID (same slicing)
//   src_pop_o          one-hot pop strobe back to the FIFOs
//   reg_ready_i        register-file port accepts a write this cycle
//   reg_we_o/waddr/wdata  register write port
//   commit_valid_o     one pulse per retired entry (x0 writes included)
//   commit_id_o        commit ID of the retired entry, 0 when stage empty
//   busy_o             stage holds an entry or any FIFO is non-empty
// Round-robin grant among non-empty FIFOs, one registered output stage.

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 6
`endif

// Per-source request: req_hi marks sources at or above the rr pointer,
// which take priority so the search wraps from rr_ptr.
module wb_drain_src #(
  parameter int IDX   = 0,
  parameter int PTR_W = 2
) (
  input  logic             empty_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic             req_o,
  output logic             req_hi_o
);
  assign req_o    = !empty_i;
  assign req_hi_o = !empty_i && (PTR_W'(IDX) >= rr_ptr_i);
endmodule

module wb_drain_arb #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = `REG_DATA_WIDTH,
  parameter int ADDR_W  = `REG_ADDR_WIDTH,
  parameter int CID_W   = `COMMIT_ID_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_empty_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_wdata_i,
  input  logic [NUM_SRC*ADDR_W-1:0] src_waddr_i,
  input  logic [NUM_SRC*CID_W-1:0]  src_cid_i,
  output logic [NUM_SRC-1:0]        src_pop_o,
  input  logic                      reg_ready_i,
  output logic                      reg_we_o,
  output logic [ADDR_W-1:0]         reg_waddr_o,
  output logic [DATA_W-1:0]         reg_wdata_o,
  output logic                      commit_valid_o,
  output logic [CID_W-1:0]          commit_id_o,
  output logic                      busy_o
);
  localparam int PTR_W = $clog2(NUM_SRC);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_e;

  stage_e                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]     stage_waddr_q, stage_waddr_d;
  logic [DATA_W-1:0]     stage_wdata_q, stage_wdata_d;
  logic [CID_W-1:0]      stage_cid_q, stage_cid_d;

  logic [NUM_SRC-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_SRC-1:0][ADDR_W-1:0] waddr_a;
  logic [NUM_SRC-1:0][CID_W-1:0]  cid_a;
  logic [NUM_SRC-1:0]             req, req_hi, pop;

  logic             out_valid, done, accept, take, gnt_vld;
  logic [PTR_W-1:0] gnt_idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign wdata_a[i] = src_wdata_i[i*DATA_W +: DATA_W];
    assign waddr_a[i] = src_waddr_i[i*ADDR_W +: ADDR_W];
    assign cid_a[i]   = src_cid_i[i*CID_W +: CID_W];
    wb_drain_src #(.IDX(i), .PTR_W(PTR_W)) u_src (
      .empty_i  (src_empty_i[i]),
      .rr_ptr_i (rr_ptr_q),
      .req_o    (req[i]),
      .req_hi_o (req_hi[i])
    );
  end

  // Lowest requester at/above rr_ptr wins; otherwise lowest overall (wrap).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_hi[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign out_valid = (state_q == ST_FULL);
  // x0 writes retire without waiting on the port.
  assign done      = out_valid && (reg_ready_i || stage_waddr_q == '0);
  assign accept    = !out_valid || done;
  assign take      = accept && gnt_vld;

  always_comb begin
    pop = '0;
    if (take) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    stage_waddr_d = stage_waddr_q;
    stage_wdata_d = stage_wdata_q;
    stage_cid_d   = stage_cid_q;
    if (take) begin
      state_d       = ST_FULL;
      stage_waddr_d = waddr_a[gnt_idx];
      stage_wdata_d = wdata_a[gnt_idx];
      stage_cid_d   = cid_a[gnt_idx];
      rr_ptr_d      = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (done) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      rr_ptr_q      <= '0;
      stage_waddr_q <= '0;
      stage_wdata_q <= '0;
      stage_cid_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      stage_waddr_q <= stage_waddr_d;
      stage_wdata_q <= stage_wdata_d;
      stage_cid_q   <= stage_cid_d;
    end
  end

  // No pops while held in reset: the stage would discard the entry.
  assign src_pop_o      = rst_n ? pop : '0;
  assign reg_we_o       = out_valid && (stage_waddr_q != '0);
  assign reg_waddr_o    = stage_waddr_q;
  assign reg_wdata_o    = stage_wdata_q;
  assign commit_valid_o = done;
  assign commit_id_o    = out_valid ? stage_cid_q : '0;
  assign busy_o         = out_valid || (|(~src_empty_i));
endmodule

// File: doc/wb_drain_arb.md
Name: wb_drain_arb

Overview:
- Consumer end of the register writeback FIFOs: pops entries from up to NUM_SRC writeback FIFOs (one per execution unit) and drives the single register-file write port.
- Arbitrates round-robin among non-empty FIFOs and registers the selected entry into one output stage.
- Honours port backpressure and reports every retired entry's commit ID to the commit/scoreboard logic.

Parameters:
- NUM_SRC, 3, number of writeback FIFOs drained (2..8)
- DATA_W, `REG_DATA_WIDTH, register data width
- ADDR_W, `REG_ADDR_WIDTH, register address width
- CID_W, `COMMIT_ID_WIDTH, commit ID width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- src_empty_i  in  NUM_SRC  per-FIFO empty flag
- src_wdata_i  in  NUM_SRC*DATA_W  per-FIFO head data; slice i = bits [i*DATA_W +: DATA_W]
- src_waddr_i  in  NUM_SRC*ADDR_W  per-FIFO head register address
- src_cid_i  in  NUM_SRC*CID_W  per-FIFO head commit ID
- src_pop_o  out  NUM_SRC  one-hot pop strobe to the FIFOs
- reg_ready_i  in  1  register-file port can accept a write this cycle
- reg_we_o  out  1  register write enable
- reg_waddr_o  out  ADDR_W  register write address
- reg_wdata_o  out  DATA_W  register write data
- commit_valid_o  out  1  one-cycle pulse: one entry retired
- commit_id_o  out  CID_W  commit ID of the retired entry
- busy_o  out  1  output stage valid, or any source non-empty

Behaviour:
- Reset is synchronous and active-low; clk and rst_n are the only clock and reset.
- On reset: out_valid=0, rr_ptr=0, stage registers=0.
  - Resulting outputs: reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, commit_valid_o=0, commit_id_o=0.
  - src_pop_o=0 while rst_n=0.
- Stage states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- done = out_valid && (reg_ready_i || stage_waddr==0).
  - Writes to x0 complete without waiting on the port.
- accept = !out_valid || done.
- Grant (combinational):
  - Choose the first i with !src_empty_i[i], searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_SRC.
  - src_pop_o[i]=1 only if accept and a grant exists.
  - At most one pop bit is ever set.
- On a grant at edge T:
  - Load stage with slice i; out_valid=1; rr_ptr <= (i==NUM_SRC-1) ? 0 : i+1.
  - The entry appears at outputs in cycle T+1 (1-cycle latency from the pop).
- done with no grant: out_valid <= 0.
- done with a grant: the stage reloads back-to-back. Sustained throughput is 1 entry/cycle.
- !accept: no pop; stage, rr_ptr and outputs hold stable.
- No grant: rr_ptr holds.
- reg_we_o = out_valid && stage_waddr!=0. reg_waddr_o and reg_wdata_o mirror the stage.
- commit_valid_o = done (combinational). commit_id_o = stage commit ID, gated to 0 when out_valid=0.
  - One pulse per retired entry, including x0 entries.
- Ordering: entries from the same source retire in FIFO order. No ordering is guaranteed across sources.
- Reset mid-operation: a pending stage entry is discarded, not written and not committed. Outputs read 0 the cycle after the reset edge.
- busy_o = out_valid || (|~src_empty_i).

Test Plan:
- Reset, all sources empty for 5 cycles -> every output 0, src_pop_o=0, busy_o=0.
- Src1 holds {x5, 0xDEADBEEF, cid 3}; reg_ready_i=1 -> src_pop_o=3'b010 at T. At T+1: reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0xDEADBEEF, commit_valid_o=1, commit_id_o=3.
- All 3 sources hold 2 entries each; reg_ready_i=1 -> grant order 0,1,2,0,1,2 over 6 consecutive cycles. 6 commit pulses, no idle cycle.
- Stage holds {x7, 0x1234}; reg_ready_i=0 for 4 cycles -> outputs stable, src_pop_o=0, no commit pulse. Ready rises -> commit pulse that cycle; next entry popped in the same cycle.
- Src0 entry {x0, 0x55, cid 9} with reg_ready_i=0 -> reg_we_o=0, commit_valid_o=1 with commit_id_o=9 at T+1; next entry accepted the same cycle.
- Stage FULL with reg_ready_i=0, rst_n=0 for 1 cycle -> after the edge: out_valid=0, no commit of the held entry, rr_ptr=0.
